fx_regbank: RTL
===============

// Module: fx_regbank
// PURPOSE
//  Parametrised fx-bus register bank: per-device config, status, command and event regs.
//  Config is double-buffered: bus writes land in a shadow copy; the active copy updates on commit.
//  Adds sticky event flags with write-1-to-clear, an interrupt mask and a registered irq output.
//  One instance per sub-block, selected by fx address bits [21:16] == dev_id.
// PARAMETERS
//  N_CFG    4        config registers, 1..16
//  N_STU    2        status inputs, 1..16
//  N_CMD    1        command pulse registers, 1..16
//  N_EVT    4        sticky event bits, 1..8
//  CFG_RST  32'h0    reset value of shadow and active config, flat, byte i = [8i+7:8i]
//  VERSION  8'h01    constant returned at offset 0x01
// PORTS
//  clk_sys     in   1         system clock
//  rst_n       in   1         async active-low reset
//  dev_id      in   6         device select, compared with fx_*addr[21:16]
//  fx_wr       in   1         write strobe, one cycle per byte
//  fx_waddr    in   22        write address
//  fx_data     in   8         write data
//  fx_rd       in   1         read strobe, one cycle per byte
//  fx_raddr    in   22        read address
//  fx_q        out  8         read data, registered
//  stu_in      in   8*N_STU   status bytes, sampled on read
//  evt_in      in   N_EVT     event pulses, level-high sets flag
//  upd_strobe  in   1         external commit, e.g. frame boundary
//  cfg_out     out  8*N_CFG   active config
//  cmd_out     out  8*N_CMD   command pulses
//  irq         out  1         registered |(evt_flag & evt_mask)
// BEHAVIOUR
//  Reset: cfg shadow and active = CFG_RST; evt_flag, evt_mask, ctrl = 0; fx_q, cmd_out, irq = 0.
//  wsel = fx_wr & (fx_waddr[21:16]==dev_id); rsel = fx_rd & (fx_raddr[21:16]==dev_id).
//  Map, offset = addr[15:0]:
//   0x00 R dev_id, zero-extended; 0x01 R VERSION
//   0x08 RW1C evt_flag; 0x09 RW evt_mask, bits >= N_EVT read 0
//   0x0F CTRL: bit0 RW auto_commit; bit1 W commit, self-clearing, reads 0
//   0x10+i R stu_in byte i; 0x20+i RW cfg shadow i; 0x30+i W cmd i; 0x40+i R cfg active i
//  Any other offset, or an index >= N_*: writes are ignored; reads return 8'h55.
//  Read: fx_q is valid the cycle after rsel, then returns to 0. 1-cycle latency, no wait states.
//  cmd_out byte i = fx_data for the cycle after wsel at 0x30+i, else 0. Registered, 1-cycle pulse.
//  Commit copies all shadow regs to active in one cycle. A commit occurs on:
//   - upd_strobe=1 with auto_commit=0
//   - a CTRL write with bit1=1, regardless of auto_commit
//  auto_commit=1: a shadow write also updates that active reg in the same edge; upd_strobe is ignored.
//  Shadow write coinciding with a commit: active takes the pre-write shadow; the new value stays in shadow only.
//  evt_flag[k] <= evt_in[k] | (flag[k] & ~(W1C write bit k)). Set wins over a same-cycle clear.
//  irq is registered: it rises the cycle after a flag/mask change and stays high until cleared or masked.
//  Read of evt_flag is non-destructive.
//  Reset mid-operation: all state reverts immediately; a pending cmd pulse or read data is dropped.
// TESTING
//  Reset -> cfg_out=CFG_RST, read 0x00 returns dev_id, read 0x01 returns VERSION, read 0x7F returns 8'h55.
//  Write 0x20=0xA5, auto=0 -> read 0x20=0xA5, read 0x40=old value; upd_strobe -> 0x40=0xA5 and cfg_out updates.
//  Write 0x0F=0x01, then 0x21=0x3C -> cfg_out byte1=0x3C on the same edge; upd_strobe has no effect.
//  evt_in[2] pulse with mask=0x04 -> flag=0x04, irq=1 next cycle; write 0x08=0x04 -> irq=0; W1C with evt_in[2] high -> flag stays set.
//  Write 0x30=0x5A -> cmd_out[7:0]=0x5A for exactly one cycle; wrong dev_id -> no pulse, no reg change.
//  Commit on the same cycle as shadow write 0x22=0x77 -> active keeps the old value, next commit -> 0x77.

Source files
------------

// File: rtl/fx_regbank.sv
// fx-bus register bank: double-buffered config, status, command pulses and sticky events with irq.
// Selected when fx address bits [21:16] match dev_id; offsets live in address bits [15:0].
module fx_regbank #(
    parameter int unsigned         N_CFG   = 4,
    parameter int unsigned         N_STU   = 2,
    parameter int unsigned         N_CMD   = 1,
    parameter int unsigned         N_EVT   = 4,
    parameter logic [8*N_CFG-1:0]  CFG_RST = '0,
    parameter logic [7:0]          VERSION = 8'h01
) (
    input  logic                 clk_sys,
    input  logic                 rst_n,
    input  logic [5:0]           dev_id,
    input  logic                 fx_wr,
    input  logic [21:0]          fx_waddr,
    input  logic [7:0]           fx_data,
    input  logic                 fx_rd,
    input  logic [21:0]          fx_raddr,
    output logic [7:0]           fx_q,
    input  logic [8*N_STU-1:0]   stu_in,
    input  logic [N_EVT-1:0]     evt_in,
    input  logic                 upd_strobe,
    output logic [8*N_CFG-1:0]   cfg_out,
    output logic [8*N_CMD-1:0]   cmd_out,
    output logic                 irq
);

    localparam int unsigned CFG_W = 8 * N_CFG;
    localparam int unsigned CMD_W = 8 * N_CMD;

    localparam logic [15:0] OFF_ID   = 16'h0000;
    localparam logic [15:0] OFF_VER  = 16'h0001;
    localparam logic [15:0] OFF_EVT  = 16'h0008;
    localparam logic [15:0] OFF_MASK = 16'h0009;
    localparam logic [15:0] OFF_CTRL = 16'h000F;
    localparam logic [15:0] OFF_STU  = 16'h0010;
    localparam logic [15:0] OFF_CFG  = 16'h0020;
    localparam logic [15:0] OFF_CMD  = 16'h0030;
    localparam logic [15:0] OFF_ACT  = 16'h0040;
    localparam logic [7:0]  RD_MISS  = 8'h55;

    logic [CFG_W-1:0]  cfg_shadow;
    logic [CFG_W-1:0]  cfg_active;
    logic              auto_commit;
    logic [N_EVT-1:0]  evt_flag;
    logic [N_EVT-1:0]  evt_mask;

    logic              wsel_c;
    logic              rsel_c;
    logic [15:0]       woff_c;
    logic [15:0]       roff_c;
    logic [N_CFG-1:0]  wr_cfg_c;
    logic              wr_ctrl_c;
    logic              commit_c;
    logic [N_EVT-1:0]  w1c_c;
    logic [CMD_W-1:0]  cmd_c;
    logic [7:0]        rdata_c;

    assign wsel_c = fx_wr & (fx_waddr[21:16] == dev_id);
    assign rsel_c = fx_rd & (fx_raddr[21:16] == dev_id);
    assign woff_c = fx_waddr[15:0];
    assign roff_c = fx_raddr[15:0];

    assign wr_ctrl_c = wsel_c && (woff_c == OFF_CTRL);
    // Explicit commit bypasses auto_commit; the external strobe only counts in manual mode.
    assign commit_c  = (upd_strobe & ~auto_commit) | (wr_ctrl_c & fx_data[1]);
    assign w1c_c     = (wsel_c && (woff_c == OFF_EVT)) ? fx_data[N_EVT-1:0] : '0;

    // Write decode for indexed regions and next command pulse value.
    always_comb begin
        wr_cfg_c = '0;
        cmd_c    = '0;
        for (int i = 0; i < int'(N_CFG); i++) begin
            wr_cfg_c[i] = wsel_c && (woff_c == 16'(OFF_CFG + 16'(i)));
        end
        for (int i = 0; i < int'(N_CMD); i++) begin
            if (wsel_c && (woff_c == 16'(OFF_CMD + 16'(i)))) begin
                cmd_c[8*i +: 8] = fx_data;
            end
        end
    end

    // Read mux; unmapped offsets and out-of-range indices return the miss pattern.
    always_comb begin
        rdata_c = RD_MISS;
        case (roff_c)
            OFF_ID:   rdata_c = {2'b00, dev_id};
            OFF_VER:  rdata_c = VERSION;
            OFF_EVT:  rdata_c = 8'(evt_flag);
            OFF_MASK: rdata_c = 8'(evt_mask);
            OFF_CTRL: rdata_c = {7'b0, auto_commit};
            default:  rdata_c = RD_MISS;
        endcase
        for (int i = 0; i < int'(N_STU); i++) begin
            if (roff_c == 16'(OFF_STU + 16'(i))) rdata_c = stu_in[8*i +: 8];
        end
        for (int i = 0; i < int'(N_CFG); i++) begin
            if (roff_c == 16'(OFF_CFG + 16'(i))) rdata_c = cfg_shadow[8*i +: 8];
            if (roff_c == 16'(OFF_ACT + 16'(i))) rdata_c = cfg_active[8*i +: 8];
        end
    end

    // Shadow/active config; a commit takes the pre-write shadow, so it wins over auto update.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            cfg_shadow <= CFG_RST;
            cfg_active <= CFG_RST;
        end else begin
            for (int i = 0; i < int'(N_CFG); i++) begin
                if (commit_c) begin
                    cfg_active[8*i +: 8] <= cfg_shadow[8*i +: 8];
                end else if (auto_commit && wr_cfg_c[i]) begin
                    cfg_active[8*i +: 8] <= fx_data;
                end
                if (wr_cfg_c[i]) begin
                    cfg_shadow[8*i +: 8] <= fx_data;
                end
            end
        end
    end

    // Control, event flags and mask.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            auto_commit <= 1'b0;
            evt_flag    <= '0;
            evt_mask    <= '0;
        end else begin
            if (wr_ctrl_c) auto_commit <= fx_data[0];
            if (wsel_c && (woff_c == OFF_MASK)) evt_mask <= fx_data[N_EVT-1:0];
            evt_flag <= evt_in | (evt_flag & ~w1c_c);
        end
    end

    // Registered outputs: read data, command pulses, interrupt.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            fx_q    <= 8'h00;
            cmd_out <= '0;
            irq     <= 1'b0;
        end else begin
            fx_q    <= rsel_c ? rdata_c : 8'h00;
            cmd_out <= cmd_c;
            irq     <= |(evt_flag & evt_mask);
        end
    end

    assign cfg_out = cfg_active;

endmodule
